// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - FSM state codes (RUN / LSTALL / JWAIT)
//   - next-PC select codes (PCSEL_*)
//   - default register-address width and stall counter width
//   - saturating increment helper, only built when HAZARD_PERF_EN is defined
package pipe_hazard_ctrl_pkg;

    localparam int AW_DEFAULT = 6;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_JWAIT  = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] PCSEL_INC = 2'b00;  // pc + 1
    localparam logic [1:0] PCSEL_REL = 2'b01;  // pc_plus_y (branch / jump-immediate)
    localparam logic [1:0] PCSEL_XRS = 2'b10;  // register jump target
    localparam logic [1:0] PCSEL_MEM = 2'b11;  // target returned by data memory

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: combinational load-use detector.
// Flags when the instruction in EX is a register-writing load whose destination
// matches a source register actually read by the instruction in ID.
// Ports:
//   rs_id, rt_id  in  AW  source registers of the ID instruction
//   use_rs, use_rt in 1   ID instruction reads rs / rt
//   rd_ex         in  AW  destination register of the EX instruction
//   mem_read      in  1   EX instruction is a load
//   reg_wrt       in  1   EX instruction writes a register
//   load_use      out 1   hazard detected
// Register 0 is deliberately not special-cased.
module hazard_cmp #(
    parameter int AW = 6
) (
    input  logic [AW-1:0] rs_id,
    input  logic [AW-1:0] rt_id,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic [AW-1:0] rd_ex,
    input  logic          mem_read,
    input  logic          reg_wrt,
    output logic          load_use
);

    always_comb begin
        load_use = mem_read & reg_wrt &
                   ((use_rs & (rs_id == rd_ex)) | (use_rt & (rt_id == rd_ex)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequences the IF/ID and ID/EX pipeline registers.
// Detects load-use hazards and redirects (branch/jump resolved in EX) and drives
// PC write-enable, IF/ID hold/flush, ID/EX bubble and next-PC select.
// Ports:
//   clock, reset                rising-edge clock, synchronous active-high reset
//   rs_id, rt_id, useRs_id, useRt_id   ID-stage source operands
//   rd_ex, memRead_ex, regWrt_ex       EX-stage destination / load info
//   branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex, zero_ex, neg_ex
//                               EX-stage control-flow resolution
//   pcWrite, ifIdWrite, ifIdFlush, idExBubble, pcSel[1:0]   pipeline controls
//   ctrlState[1:0]              current FSM state (debug)
//   stallCount, flushCount      performance counters, present only when the
//                               HAZARD_PERF_EN macro is defined
//
// state  | meaning
// RUN    | normal issue; resolves redirects and load-use hazards combinationally
// LSTALL | extra load-use bubbles beyond the first; hazard inputs ignored
// JWAIT  | waiting for a memory-indirect jump target; front end flushed
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW                = AW_DEFAULT,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int JMEM_WAIT_CYCLES  = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] rs_id,
    input  logic [AW-1:0] rt_id,
    input  logic          useRs_id,
    input  logic          useRt_id,
    input  logic [AW-1:0] rd_ex,
    input  logic          memRead_ex,
    input  logic          regWrt_ex,
    input  logic          branchZero_ex,
    input  logic          branchNeg_ex,
    input  logic          jump_ex,
    input  logic          jumpMem_ex,
    input  logic          zero_ex,
    input  logic          neg_ex,
    output logic          pcWrite,
    output logic          ifIdWrite,
    output logic          ifIdFlush,
    output logic          idExBubble,
    output logic [1:0]    pcSel,
`ifdef HAZARD_PERF_EN
    output logic [31:0]   stallCount,
    output logic [31:0]   flushCount,
`endif
    output logic [1:0]    ctrlState
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             redirect;

    hazard_cmp #(.AW(AW)) u_hazard_cmp (
        .rs_id    (rs_id),
        .rt_id    (rt_id),
        .use_rs   (useRs_id),
        .use_rt   (useRt_id),
        .rd_ex    (rd_ex),
        .mem_read (memRead_ex),
        .reg_wrt  (regWrt_ex),
        .load_use (load_use)
    );

    always_comb begin
        redirect = jump_ex | jumpMem_ex | (branchZero_ex & zero_ex) | (branchNeg_ex & neg_ex);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (jumpMem_ex) begin
                    cnt_d   = CNT_W'(JMEM_WAIT_CYCLES - 1);
                    state_d = ST_JWAIT;
                end else if (!redirect && load_use && (LOAD_STALL_CYCLES > 1)) begin
                    // The RUN cycle itself supplies the first bubble.
                    cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 2);
                    state_d = ST_LSTALL;
                end
            end
            ST_LSTALL, ST_JWAIT: begin
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        pcSel      = PCSEL_INC;
        if (reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else begin
            case (state_q)
                ST_LSTALL: begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end
                ST_JWAIT: begin
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                    if (cnt_q != '0) pcWrite = 1'b0;
                    else             pcSel   = PCSEL_MEM;
                end
                default: begin
                    // Priority jumpMem > jump > branch; any redirect squashes
                    // the wrong-path ID instruction, so it beats load-use.
                    if (jumpMem_ex) begin
                        pcWrite    = 1'b0;
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                    end else if (redirect) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                        pcSel      = jump_ex ? PCSEL_XRS : PCSEL_REL;
                    end else if (load_use) begin
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ctrlState = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!ifIdWrite)                  stall_count_d = sat_inc(stall_count_q);
        if (state_q == ST_RUN && redirect) flush_count_d = sat_inc(flush_count_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rs_id, rt_id, rd_ex;
    logic          useRs_id, useRt_id, memRead_ex, regWrt_ex;
    logic          branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex, zero_ex, neg_ex;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExBubble;
    logic [1:0]    pcSel, ctrlState;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stallCount, flushCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .AW(AW), .LOAD_STALL_CYCLES(2), .JMEM_WAIT_CYCLES(3)
    ) dut (
        .clock(clock), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id), .useRs_id(useRs_id), .useRt_id(useRt_id),
        .rd_ex(rd_ex), .memRead_ex(memRead_ex), .regWrt_ex(regWrt_ex),
        .branchZero_ex(branchZero_ex), .branchNeg_ex(branchNeg_ex),
        .jump_ex(jump_ex), .jumpMem_ex(jumpMem_ex), .zero_ex(zero_ex), .neg_ex(neg_ex),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExBubble(idExBubble), .pcSel(pcSel),
`ifdef HAZARD_PERF_EN
        .stallCount(stallCount), .flushCount(flushCount),
`endif
        .ctrlState(ctrlState)
    );

    task automatic clear_inputs();
        rs_id = '0; rt_id = '0; rd_ex = '0;
        useRs_id = 0; useRt_id = 0; memRead_ex = 0; regWrt_ex = 0;
        branchZero_ex = 0; branchNeg_ex = 0; jump_ex = 0; jumpMem_ex = 0;
        zero_ex = 0; neg_ex = 0;
    endtask

    // Move to the next negedge with all hazard inputs cleared.
    task automatic next_cycle();
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic expect_out(input string tag, input logic pw, input logic iw,
                              input logic fl, input logic bb, input logic [1:0] sel,
                              input logic [1:0] st);
        #1;
        checks++;
        assert (pcWrite === pw) else begin
            errors++; $error("FAIL %s pcWrite observed %b expected %b", tag, pcWrite, pw);
        end
        checks++;
        assert (ifIdWrite === iw) else begin
            errors++; $error("FAIL %s ifIdWrite observed %b expected %b", tag, ifIdWrite, iw);
        end
        checks++;
        assert (ifIdFlush === fl) else begin
            errors++; $error("FAIL %s ifIdFlush observed %b expected %b", tag, ifIdFlush, fl);
        end
        checks++;
        assert (idExBubble === bb) else begin
            errors++; $error("FAIL %s idExBubble observed %b expected %b", tag, idExBubble, bb);
        end
        checks++;
        assert (pcSel === sel) else begin
            errors++; $error("FAIL %s pcSel observed %b expected %b", tag, pcSel, sel);
        end
        checks++;
        assert (ctrlState === st) else begin
            errors++; $error("FAIL %s ctrlState observed %0d expected %0d", tag, ctrlState, st);
        end
    endtask

    task automatic set_load_use_rt(input logic [AW-1:0] r);
        memRead_ex = 1; regWrt_ex = 1; rd_ex = r; rt_id = r; useRt_id = 1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        expect_out("reset", 0, 0, 1, 1, 2'b00, 2'd0);

        next_cycle(); reset = 1'b0;
        expect_out("idle", 1, 1, 0, 0, 2'b00, 2'd0);

        // load r5 in EX, ID reads rt=r5: two stall cycles
        next_cycle(); set_load_use_rt(6'd5);
        expect_out("lu_c0", 0, 0, 0, 1, 2'b00, 2'd0);
        next_cycle();
        expect_out("lu_c1", 0, 0, 0, 1, 2'b00, 2'd1);
        next_cycle();
        expect_out("lu_done", 1, 1, 0, 0, 2'b00, 2'd0);

        // taken branch-if-zero beats a concurrent load-use
        next_cycle(); set_load_use_rt(6'd5); branchZero_ex = 1; zero_ex = 1;
        expect_out("bz_lu", 1, 1, 1, 1, 2'b01, 2'd0);
        next_cycle();
        expect_out("bz_after", 1, 1, 0, 0, 2'b00, 2'd0);

        next_cycle(); branchNeg_ex = 1; neg_ex = 0;
        expect_out("bn_nottaken", 1, 1, 0, 0, 2'b00, 2'd0);
        next_cycle(); branchNeg_ex = 1; neg_ex = 1;
        expect_out("bn_taken", 1, 1, 1, 1, 2'b01, 2'd0);
        next_cycle(); zero_ex = 1;
        expect_out("zero_no_branch", 1, 1, 0, 0, 2'b00, 2'd0);
        next_cycle(); jump_ex = 1;
        expect_out("jump", 1, 1, 1, 1, 2'b10, 2'd0);
        next_cycle(); jump_ex = 1; branchZero_ex = 1; zero_ex = 1;
        expect_out("jump_over_br", 1, 1, 1, 1, 2'b10, 2'd0);

        // memory-indirect jump with a 3-cycle wait; jump flag also set
        next_cycle(); jumpMem_ex = 1; jump_ex = 1;
        expect_out("jm_c0", 0, 1, 1, 1, 2'b00, 2'd0);
        next_cycle();
        expect_out("jm_c1", 0, 1, 1, 1, 2'b00, 2'd2);
        next_cycle(); jump_ex = 1; memRead_ex = 1;
        expect_out("jm_c2", 0, 1, 1, 1, 2'b00, 2'd2);
        next_cycle();
        expect_out("jm_c3", 1, 1, 1, 1, 2'b11, 2'd2);
        next_cycle();
        expect_out("jm_after", 1, 1, 0, 0, 2'b00, 2'd0);

        // rs-path qualifiers
        next_cycle(); memRead_ex = 1; regWrt_ex = 1; rd_ex = 6'd7; rs_id = 6'd7; useRs_id = 0;
        expect_out("rs_unused", 1, 1, 0, 0, 2'b00, 2'd0);
        next_cycle(); memRead_ex = 0; regWrt_ex = 1; rd_ex = 6'd7; rs_id = 6'd7; useRs_id = 1;
        expect_out("not_load", 1, 1, 0, 0, 2'b00, 2'd0);
        next_cycle(); memRead_ex = 1; regWrt_ex = 1; rd_ex = 6'd7; rs_id = 6'd6; useRs_id = 1;
        expect_out("rs_mismatch", 1, 1, 0, 0, 2'b00, 2'd0);

        // rs hazard, then reset in second stall cycle
        next_cycle(); memRead_ex = 1; regWrt_ex = 1; rd_ex = 6'd7; rs_id = 6'd7; useRs_id = 1;
        expect_out("rs_lu_c0", 0, 0, 0, 1, 2'b00, 2'd0);
        next_cycle(); reset = 1'b1;
        expect_out("rst_in_lstall", 0, 0, 1, 1, 2'b00, 2'd1);
        next_cycle(); reset = 1'b0;
        expect_out("rst_release", 1, 1, 0, 0, 2'b00, 2'd0);

        // register 0 still triggers the hazard
        next_cycle(); set_load_use_rt(6'd0);
        expect_out("r0_lu_c0", 0, 0, 0, 1, 2'b00, 2'd0);
        next_cycle();
        expect_out("r0_lu_c1", 0, 0, 0, 1, 2'b00, 2'd1);
        next_cycle();
        expect_out("r0_done", 1, 1, 0, 0, 2'b00, 2'd0);

`ifdef HAZARD_PERF_EN
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        next_cycle(); branchZero_ex = 1; zero_ex = 1;
        next_cycle(); jump_ex = 1;
        next_cycle(); branchNeg_ex = 1; neg_ex = 1;
        next_cycle(); set_load_use_rt(6'd3);
        next_cycle();
        next_cycle();
        #1;
        checks++;
        assert (flushCount === 32'd3) else begin
            errors++; $error("FAIL perf_flush observed %0d expected 3", flushCount);
        end
        checks++;
        assert (stallCount === 32'd2) else begin
            errors++; $error("FAIL perf_stall observed %0d expected 2", stallCount);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
